// File: rtl/frame_sched_pkg.sv
// Shared constants for the frame write scheduler: FSM encodings,
// frame geometry and the header field layout.
package frame_sched_pkg;

    // FSM state encodings
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_FILL  = 2'd1;
    localparam state_t S_EMIT  = 2'd2;
    localparam state_t S_ABORT = 2'd3;

    // Frame geometry: one header word followed by the payload slots
    localparam int FRAME_WORDS   = 8;
    localparam int PAYLOAD_WORDS = 7;

    // Header layout: {tag, source id, payload count, sequence number}
    localparam logic [3:0] HDR_TAG     = 4'hA;
    localparam int         HDR_TAG_LSB = 12;
    localparam int         HDR_TAG_W   = 4;
    localparam int         HDR_SRC_LSB = 10;
    localparam int         HDR_SRC_W   = 2;
    localparam int         HDR_CNT_LSB = 7;
    localparam int         HDR_CNT_W   = 3;
    localparam int         HDR_SEQ_LSB = 0;
    localparam int         HDR_SEQ_W   = 7;

    function automatic logic [15:0] make_header(input logic [HDR_SRC_W-1:0] src,
                                                input logic [HDR_CNT_W-1:0] cnt,
                                                input logic [HDR_SEQ_W-1:0] seq);
        logic [15:0] h;
        h = '0;
        h[HDR_TAG_LSB +: HDR_TAG_W] = HDR_TAG;
        h[HDR_SRC_LSB +: HDR_SRC_W] = src;
        h[HDR_CNT_LSB +: HDR_CNT_W] = cnt;
        h[HDR_SEQ_LSB +: HDR_SEQ_W] = seq;
        return h;
    endfunction

endpackage

// File: rtl/frame_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found at
// or after the pointer, wrapping modulo NSRC. Returns one-hot and index.
module rr_arbiter #(
    parameter int NSRC  = 2,
    parameter int IDX_W = 2
) (
    input  logic [NSRC-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NSRC-1:0]  grantOh,
    output logic [IDX_W-1:0] grantIdx,
    output logic             anyGrant
);

    // Scan distances from farthest to nearest so the nearest requester wins
    always_comb begin
        grantOh  = '0;
        grantIdx = '0;
        anyGrant = 1'b0;
        for (int k = NSRC - 1; k >= 0; k--) begin
            for (int i = 0; i < NSRC; i++) begin
                if (i == ((int'(ptr) + k) % NSRC) && req[i]) begin
                    grantOh    = '0;
                    grantOh[i] = 1'b1;
                    grantIdx   = IDX_W'(i);
                    anyGrant   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/frame_sched.sv
// Write-side scheduler for the 8-word-frame packet buffer. One source at a
// time fills a 7-word local buffer; the frame is then emitted as a header
// plus payload on consecutive cycles. Loss of sync aborts the frame with a
// one-cycle PacketReset pulse.
//
// Handshake: a word on source i transfers on a rising wrClk edge where
// srcValid[i] and srcReady[i] are both high; srcValid must hold with stable
// data until that edge. srcReady is only ever high for the granted source
// while filling with sync high.
module frame_sched
    import frame_sched_pkg::*;
#(
    parameter int          NSRC         = 2,
    parameter int          FLUSH_CYCLES = 64,
    parameter logic [15:0] PAD_WORD     = 16'h0000
) (
    input  logic               wrClk,
    input  logic               rst,
    input  logic               sync,
    input  logic [NSRC-1:0]    srcValid,
    input  logic [NSRC-1:0]    srcLast,
    input  logic [16*NSRC-1:0] srcData,
    output logic [NSRC-1:0]    srcReady,
    output logic               WdAvail,
    output logic [15:0]        PacketWd,
    output logic               PacketReset,
    output logic [15:0]        abortCount,
    output logic [1:0]         dbgState
);

    localparam int             TO_W    = $clog2(FLUSH_CYCLES) + 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(FLUSH_CYCLES - 1);

    state_t          state;
    logic [1:0]      grant;
    logic [NSRC-1:0] grantOhQ;
    logic [2:0]      count;
    logic [TO_W-1:0] timeout;
    logic [6:0]      seq;
    logic [1:0]      rrPtr;
    logic [2:0]      emitIdx;
    logic [15:0]     payload [PAYLOAD_WORDS];

    logic [NSRC-1:0] arbOh;
    logic [1:0]      arbIdx;
    logic            arbAny;
    logic [15:0]     selData;
    logic            selLast;
    logic            accept;
    logic            closeOnAccept;
    logic [2:0]      slot;
    logic [15:0]     emitWord;
    logic [1:0]      nextPtr;

    rr_arbiter #(.NSRC(NSRC), .IDX_W(2)) u_arb (
        .req      (srcValid),
        .ptr      (rrPtr),
        .grantOh  (arbOh),
        .grantIdx (arbIdx),
        .anyGrant (arbAny)
    );

    assign dbgState = state;

    // Only the granted source may transfer, and only while filling in sync
    always_comb begin
        srcReady = '0;
        if (!rst && state == S_FILL && sync) srcReady = grantOhQ;
    end

    // Route the granted source's word and last flag
    always_comb begin
        selData = '0;
        selLast = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (grantOhQ[i]) begin
                selData = srcData[16*i +: 16];
                selLast = srcLast[i];
            end
        end
    end

    assign accept        = (state == S_FILL) && sync && |(srcValid & grantOhQ);
    assign closeOnAccept = accept && ((count == 3'(PAYLOAD_WORDS - 1)) || selLast);
    assign nextPtr       = (grant == 2'(NSRC - 1)) ? 2'd0 : grant + 2'd1;

    // Select the frame word for the current emit slot; unfilled slots pad
    always_comb begin
        slot = emitIdx - 3'd1;
        if (emitIdx == 3'd0) begin
            emitWord = make_header(grant, count, seq);
        end else if (slot >= count) begin
            emitWord = PAD_WORD;
        end else begin
            emitWord = payload[slot];
        end
    end

    // Payload capture; contents are only meaningful below count
    always_ff @(posedge wrClk) begin
        if (accept) payload[count] <= selData;
    end

    // Scheduler FSM and registered frame outputs
    always_ff @(posedge wrClk) begin
        if (rst) begin
            state       <= S_IDLE;
            grant       <= '0;
            grantOhQ    <= '0;
            count       <= '0;
            timeout     <= '0;
            seq         <= '0;
            rrPtr       <= '0;
            emitIdx     <= '0;
            WdAvail     <= 1'b0;
            PacketWd    <= '0;
            PacketReset <= 1'b0;
            abortCount  <= '0;
        end else begin
            WdAvail     <= 1'b0;
            PacketReset <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (sync && arbAny) begin
                        grant    <= arbIdx;
                        grantOhQ <= arbOh;
                        count    <= '0;
                        timeout  <= '0;
                        state    <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (!sync) begin
                        PacketReset <= 1'b1;
                        if (abortCount != 16'hFFFF) abortCount <= abortCount + 16'd1;
                        state <= S_ABORT;
                    end else if (accept) begin
                        count   <= count + 3'd1;
                        timeout <= '0;
                        if (closeOnAccept) begin
                            emitIdx <= '0;
                            state   <= S_EMIT;
                        end
                    end else if (timeout == TO_LAST && count != 3'd0) begin
                        emitIdx <= '0;
                        state   <= S_EMIT;
                    end else if (timeout != TO_LAST) begin
                        timeout <= timeout + TO_W'(1);
                    end
                end
                S_EMIT: begin
                    if (!sync) begin
                        PacketReset <= 1'b1;
                        if (abortCount != 16'hFFFF) abortCount <= abortCount + 16'd1;
                        state <= S_ABORT;
                    end else begin
                        WdAvail  <= 1'b1;
                        PacketWd <= emitWord;
                        emitIdx  <= emitIdx + 3'd1;
                        if (emitIdx == 3'(FRAME_WORDS - 1)) begin
                            seq   <= seq + 7'd1;
                            rrPtr <= nextPtr;
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_sched.sv
// Self-checking bench for frame_sched: directed scenarios plus a randomized
// two-source run, all checked against a frame-level reference model.
module tb_frame_sched;

    localparam int          NSRC  = 2;
    localparam int          FLUSH = 64;
    localparam logic [15:0] PAD   = 16'h0000;
    localparam logic [1:0]  IDLE_ST = 2'd0;

    logic        wrClk;
    logic        rst;
    logic        sync;
    logic [1:0]  srcValid;
    logic [1:0]  srcLast;
    logic [31:0] srcData;
    logic [1:0]  srcReady;
    logic        WdAvail;
    logic [15:0] PacketWd;
    logic        PacketReset;
    logic [15:0] abortCount;
    logic [1:0]  dbgState;

    frame_sched #(.NSRC(NSRC), .FLUSH_CYCLES(FLUSH), .PAD_WORD(PAD)) dut (
        .wrClk       (wrClk),
        .rst         (rst),
        .sync        (sync),
        .srcValid    (srcValid),
        .srcLast     (srcLast),
        .srcData     (srcData),
        .srcReady    (srcReady),
        .WdAvail     (WdAvail),
        .PacketWd    (PacketWd),
        .PacketReset (PacketReset),
        .abortCount  (abortCount),
        .dbgState    (dbgState)
    );

    // Clock
    initial wrClk = 1'b0;
    always #5 wrClk = ~wrClk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lastAccCyc = 0;
    int firstAvailCyc = -1;
    int runLen = 0;
    int prstCount = 0;
    int readyInEmit = 0;
    int seq_m = 0;
    int ptr_m = 0;

    logic [16:0] q0[$];
    logic [16:0] q1[$];
    logic [15:0] stage_q[$];
    logic [15:0] cap_q[$];
    logic [15:0] exp_q[$];

    // Driver: present each source's queue head ({last, data})
    task automatic drive_inputs();
        srcValid[0]    = (q0.size() != 0);
        srcLast[0]     = (q0.size() != 0) ? q0[0][16] : 1'b0;
        srcData[15:0]  = (q0.size() != 0) ? q0[0][15:0] : 16'h0;
        srcValid[1]    = (q1.size() != 0);
        srcLast[1]     = (q1.size() != 0) ? q1[0][16] : 1'b0;
        srcData[31:16] = (q1.size() != 0) ? q1[0][15:0] : 16'h0;
    endtask

    // One clock: note transfers, advance, sample outputs, update drive
    task automatic run_cycle();
        logic [1:0]  acc;
        logic [16:0] dummy;
        @(negedge wrClk);
        acc = srcValid & srcReady;
        @(posedge wrClk);
        #1;
        cyc++;
        if (acc[0] && q0.size() != 0) begin dummy = q0.pop_front(); lastAccCyc = cyc; end
        if (acc[1] && q1.size() != 0) begin dummy = q1.pop_front(); lastAccCyc = cyc; end
        if (WdAvail) begin
            cap_q.push_back(PacketWd);
            if (firstAvailCyc < 0) firstAvailCyc = cyc;
            runLen++;
            if (srcReady != 2'b00) readyInEmit++;
        end else begin
            if (runLen != 0) begin
                checks++;
                if (runLen != 8 && !PacketReset) begin
                    errors++;
                    $display("FAIL frame_contiguity: run of %0d words, required 8", runLen);
                end
                runLen = 0;
            end
        end
        if (PacketReset) prstCount++;
        drive_inputs();
    endtask

    // Reference model: header from source, staged payload count and sequence
    task automatic expect_frame(input int src);
        logic [15:0] h;
        int n;
        n = stage_q.size();
        h = 16'hA000 | 16'(src << 10) | 16'(n << 7) | 16'(seq_m);
        exp_q.push_back(h);
        for (int i = 0; i < 7; i++) exp_q.push_back((i < n) ? stage_q[i] : PAD);
        seq_m = (seq_m + 1) % 128;
        ptr_m = (src + 1) % NSRC;
        stage_q.delete();
    endtask

    task automatic wait_words(input int n, input int budget, output bit ok);
        while (cap_q.size() < n && budget > 0) begin
            run_cycle();
            budget--;
        end
        ok = (cap_q.size() >= n);
    endtask

    task automatic wait_drained(input int budget, output bit ok);
        while ((q0.size() != 0 || q1.size() != 0) && budget > 0) begin
            run_cycle();
            budget--;
        end
        ok = (q0.size() == 0 && q1.size() == 0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        sync = 1'b1;
        q0.delete();
        q1.delete();
        runLen = 0;
        drive_inputs();
        run_cycle();
        run_cycle();
        rst = 1'b0;
        cap_q.delete();
        exp_q.delete();
        stage_q.delete();
        firstAvailCyc = -1;
        seq_m = 0;
        ptr_m = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sync = 1'b1;
        q0.push_back({1'b0, 16'h1234});
        drive_inputs();
        run_cycle();
        checks++; if (srcReady !== 2'b00) begin errors++; $display("FAIL reset_srcReady: got %b expected 00", srcReady); end
        checks++; if (WdAvail !== 1'b0) begin errors++; $display("FAIL reset_WdAvail: got %b expected 0", WdAvail); end
        checks++; if (PacketWd !== 16'h0) begin errors++; $display("FAIL reset_PacketWd: got %h expected 0000", PacketWd); end
        checks++; if (PacketReset !== 1'b0) begin errors++; $display("FAIL reset_PacketReset: got %b expected 0", PacketReset); end
        checks++; if (abortCount !== 16'h0) begin errors++; $display("FAIL reset_abortCount: got %h expected 0000", abortCount); end
        checks++; if (dbgState !== IDLE_ST) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbgState, IDLE_ST); end
        apply_reset();
    endtask

    task automatic test_full_frame();
        bit ok;
        for (int i = 1; i <= 7; i++) begin
            q0.push_back({1'b0, 16'(16'h0100 + i)});
            stage_q.push_back(16'(16'h0100 + i));
        end
        expect_frame(0);
        firstAvailCyc = -1;
        drive_inputs();
        wait_words(8, 60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL full_timeout: got %0d words expected 8", cap_q.size()); end
        if (ok) begin
            checks++; if (cap_q[0] !== 16'hA380) begin errors++; $display("FAIL full_header: got %h expected A380", cap_q[0]); end
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL full_word[%0d]: got %h expected %h", i, cap_q[i], exp_q[i]); end
            end
            checks++;
            if (firstAvailCyc - lastAccCyc !== 1) begin errors++; $display("FAIL full_latency: got %0d expected 1", firstAvailCyc - lastAccCyc); end
        end
        run_cycle();
        run_cycle();
        cap_q.delete();
        exp_q.delete();
    endtask

    task automatic test_short_burst();
        bit ok;
        logic [15:0] d;
        logic [15:0] hdr_exp;
        hdr_exp = 16'hA580 | 16'(seq_m);
        for (int i = 0; i < 3; i++) begin
            d = 16'($urandom);
            q1.push_back({(i == 2), d});
            stage_q.push_back(d);
        end
        q1.push_back({1'b0, 16'($urandom)});
        expect_frame(1);
        readyInEmit = 0;
        drive_inputs();
        wait_words(8, 60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL short_timeout: got %0d words expected 8", cap_q.size()); end
        if (ok) begin
            checks++; if (cap_q[0] !== hdr_exp) begin errors++; $display("FAIL short_header: got %h expected %h", cap_q[0], hdr_exp); end
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL short_word[%0d]: got %h expected %h", i, cap_q[i], exp_q[i]); end
            end
        end
        checks++; if (readyInEmit !== 0) begin errors++; $display("FAIL short_ready_in_emit: got %0d cycles expected 0", readyInEmit); end
        apply_reset();
    endtask

    task automatic test_timeout_flush();
        bit ok;
        logic [15:0] d;
        for (int i = 0; i < 2; i++) begin
            d = 16'($urandom);
            q0.push_back({1'b0, d});
            stage_q.push_back(d);
        end
        expect_frame(0);
        firstAvailCyc = -1;
        drive_inputs();
        wait_words(8, 120, ok);
        checks++; if (!ok) begin errors++; $display("FAIL flush_timeout: got %0d words expected 8", cap_q.size()); end
        if (ok) begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL flush_word[%0d]: got %h expected %h", i, cap_q[i], exp_q[i]); end
            end
            checks++;
            if (firstAvailCyc - lastAccCyc !== FLUSH + 1) begin
                errors++;
                $display("FAIL flush_latency: got %0d expected %0d", firstAvailCyc - lastAccCyc, FLUSH + 1);
            end
        end
        run_cycle();
        cap_q.delete();
        exp_q.delete();
    endtask

    task automatic test_alternate_random();
        bit ok;
        logic [16:0] m0[$];
        logic [16:0] m1[$];
        logic [16:0] w;
        int src;
        for (int i = 0; i < 30; i++) begin
            w = {($urandom_range(0, 3) == 0), 16'($urandom)};
            q0.push_back(w); m0.push_back(w);
            w = {($urandom_range(0, 3) == 0), 16'($urandom)};
            q1.push_back(w); m1.push_back(w);
        end
        for (int f = 0; f < 8; f++) begin
            src = ptr_m;
            do begin
                if (src == 0) w = m0.pop_front();
                else          w = m1.pop_front();
                stage_q.push_back(w[15:0]);
            end while (!w[16] && stage_q.size() < 7);
            expect_frame(src);
        end
        drive_inputs();
        wait_words(64, 400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL alt_timeout: got %0d words expected 64", cap_q.size()); end
        if (ok) begin
            for (int i = 0; i < 64; i++) begin
                checks++;
                if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL alt_word[%0d]: got %h expected %h", i, cap_q[i], exp_q[i]); end
            end
        end
        apply_reset();
    endtask

    task automatic test_sync_loss();
        bit ok;
        int prst_base;
        logic [15:0] d;
        logic [15:0] hdr_exp;
        prst_base = prstCount;
        hdr_exp = 16'hA180 | 16'(seq_m);
        for (int i = 0; i < 3; i++) q0.push_back({(i == 2), 16'($urandom)});
        drive_inputs();
        wait_words(3, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL abort_emit_start: got %0d words expected 3", cap_q.size()); end
        sync = 1'b0;
        run_cycle();
        checks++; if (WdAvail !== 1'b0) begin errors++; $display("FAIL abort_emit_WdAvail: got %b expected 0", WdAvail); end
        checks++; if (PacketReset !== 1'b1) begin errors++; $display("FAIL abort_emit_PacketReset: got %b expected 1", PacketReset); end
        checks++; if (abortCount !== 16'd1) begin errors++; $display("FAIL abort_emit_count: got %0d expected 1", abortCount); end
        checks++; if (cap_q.size() !== 3) begin errors++; $display("FAIL abort_emit_words: got %0d expected 3", cap_q.size()); end
        if (cap_q.size() != 0) begin
            checks++; if (cap_q[0] !== hdr_exp) begin errors++; $display("FAIL abort_emit_header: got %h expected %h", cap_q[0], hdr_exp); end
        end
        sync = 1'b1;
        run_cycle();
        checks++; if (PacketReset !== 1'b0) begin errors++; $display("FAIL abort_pulse_width: got %b expected 0", PacketReset); end
        checks++; if (prstCount - prst_base !== 1) begin errors++; $display("FAIL abort_pulse_count: got %0d expected 1", prstCount - prst_base); end
        cap_q.delete();

        // Seq and pointer survive the abort: source ptr_m wins again, same seq
        d = 16'($urandom); q0.push_back({1'b1, d}); stage_q.push_back(d); expect_frame(0);
        d = 16'($urandom); q1.push_back({1'b1, d}); stage_q.push_back(d); expect_frame(1);
        drive_inputs();
        wait_words(16, 80, ok);
        checks++; if (!ok) begin errors++; $display("FAIL post_abort_timeout: got %0d words expected 16", cap_q.size()); end
        if (ok) begin
            checks++; if (cap_q[0] !== 16'hA080) begin errors++; $display("FAIL post_abort_header: got %h expected A080", cap_q[0]); end
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL post_abort_word[%0d]: got %h expected %h", i, cap_q[i], exp_q[i]); end
            end
        end
        run_cycle();
        cap_q.delete();
        exp_q.delete();

        // Abort while filling: buffered words are dropped
        q0.push_back({1'b0, 16'($urandom)});
        q0.push_back({1'b0, 16'($urandom)});
        drive_inputs();
        wait_drained(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL abort_fill_accept: got %0d pending expected 0", q0.size()); end
        sync = 1'b0;
        run_cycle();
        checks++; if (PacketReset !== 1'b1) begin errors++; $display("FAIL abort_fill_PacketReset: got %b expected 1", PacketReset); end
        checks++; if (abortCount !== 16'd2) begin errors++; $display("FAIL abort_fill_count: got %0d expected 2", abortCount); end
        sync = 1'b1;
        d = 16'($urandom); q0.push_back({1'b1, d}); stage_q.push_back(d); expect_frame(0);
        drive_inputs();
        wait_words(8, 60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL abort_fill_next: got %0d words expected 8", cap_q.size()); end
        if (ok) begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL abort_fill_word[%0d]: got %h expected %h", i, cap_q[i], exp_q[i]); end
            end
        end
        run_cycle();
        cap_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid_fill();
        bit ok;
        int prst_base;
        for (int i = 0; i < 3; i++) q0.push_back({1'b0, 16'($urandom)});
        drive_inputs();
        wait_drained(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstfill_accept: got %0d pending expected 0", q0.size()); end
        q0.push_back({1'b0, 16'($urandom)});
        drive_inputs();
        rst = 1'b1;
        #1;
        checks++; if (srcReady !== 2'b00) begin errors++; $display("FAIL rstfill_srcReady: got %b expected 00", srcReady); end
        prst_base = prstCount;
        run_cycle();
        checks++; if (WdAvail !== 1'b0) begin errors++; $display("FAIL rstfill_WdAvail: got %b expected 0", WdAvail); end
        checks++; if (PacketWd !== 16'h0) begin errors++; $display("FAIL rstfill_PacketWd: got %h expected 0000", PacketWd); end
        checks++; if (PacketReset !== 1'b0) begin errors++; $display("FAIL rstfill_PacketReset: got %b expected 0", PacketReset); end
        checks++; if (abortCount !== 16'h0) begin errors++; $display("FAIL rstfill_abortCount: got %h expected 0000", abortCount); end
        checks++; if (dbgState !== IDLE_ST) begin errors++; $display("FAIL rstfill_state: got %0d expected %0d", dbgState, IDLE_ST); end
        q0.delete();
        drive_inputs();
        rst = 1'b0;
        for (int i = 0; i < 100; i++) run_cycle();
        checks++; if (cap_q.size() !== 0) begin errors++; $display("FAIL rstfill_no_emit: got %0d words expected 0", cap_q.size()); end
        checks++; if (prstCount - prst_base !== 0) begin errors++; $display("FAIL rstfill_no_pulse: got %0d pulses expected 0", prstCount - prst_base); end
    endtask

    initial begin
        rst      = 1'b1;
        sync     = 1'b0;
        srcValid = '0;
        srcLast  = '0;
        srcData  = '0;
        test_reset();
        test_full_frame();
        test_short_burst();
        test_timeout_flush();
        test_alternate_random();
        test_sync_loss();
        test_reset_mid_fill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
